top_seg_595: RTL and testbench
==============================

TOP_SEG_595 -- requirements
Module: top_seg_595

Interface
REQ-001 Parameter DATA_CNT_MAX, default 4999999, count-interval terminal value (100 ms at 50 MHz); count period is DATA_CNT_MAX+1 clocks.
REQ-002 Parameter SCAN_CNT_MAX, default 49999, digit-scan terminal value (1 ms at 50 MHz); scan period is SCAN_CNT_MAX+1 clocks.
REQ-003 sys_clk  input  1  single system clock, 50 MHz, all state on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stcp  output  1  74HC595 storage (latch) clock.
REQ-006 shcp  output  1  74HC595 shift clock.
REQ-007 ds  output  1  74HC595 serial data.
REQ-008 oe  output  1  74HC595 output enable, active-low.
REQ-009 Hierarchy SHALL be: instance data_gen_inst (parameter CNT_MAX = DATA_CNT_MAX) and instance seg_595_dynamic_inst containing seg_dynamic_inst (parameter CNT_MAX = SCAN_CNT_MAX) and a 595 serializer; both CNT_MAX parameters SHALL be overridable by hierarchical defparam.

Function
REQ-010 Count generator: counter 0..CNT_MAX wrapping; a value register data (20 bits) SHALL increment by 1 on the clock where the counter equals CNT_MAX, wrapping 999999 -> 0.
REQ-011 Generator SHALL drive fixed display controls: point = 6'b000000 (all decimal points off), seg_en = 1, sign = 0.
REQ-012 Display decoder SHALL convert data to six BCD digits (units..hundred-thousands) by shift-add-3, producing a stable result for each data value.
REQ-013 Leading-zero blanking: every digit above the most significant non-zero digit SHALL be blank; units digit always shown (data=0 shows "0"); if sign=1 the first blank position above shows minus.
REQ-014 Scan: counter 0..SCAN_CNT_MAX; on its terminal value digit index cnt_sel advances 0..5, wrapping 5 -> 0.
REQ-015 sel (6-bit one-hot, active-high) SHALL be 000001 for cnt_sel=0 (units) shifting left to 100000 for cnt_sel=5 (hundred-thousands); reset value 000000.
REQ-016 seg (8-bit, common-anode, active-low, bit7=DP, bits6..0=g..a) SHALL decode the selected digit: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90, minus=BF, blank=FF; DP bit = ~point bit of that digit; reset value FF; seg and sel registered in the same cycle.
REQ-017 If seg_en=0, sel SHALL be 000000.
REQ-018 Serializer: 2-bit divider cnt_4 counts 0..3 continuously; bit index cnt_bit 0..13 advances when cnt_4=3, wrapping 13 -> 0.
REQ-019 Frame word (14 bits) = {seg[0],seg[1],...,seg[7],sel[5:0]}; bit 0 (sel[0]) shifted first, bit 13 (seg[0]) last.
REQ-020 ds SHALL load frame[cnt_bit] when cnt_4=0; shcp SHALL go 0 at cnt_4=0 and 1 at cnt_4=2 (period 4 clocks, 50% duty, rising edge mid-bit).
REQ-021 stcp SHALL be 1 for exactly one clock when cnt_bit=0 and cnt_4=0, else 0 (one latch pulse per 56-clock frame).
REQ-022 Frame bits sampled live from current seg/sel; no frame buffering required.
REQ-023 oe SHALL equal ~sys_rst_n (high in reset, low in operation).

Reset
REQ-024 While sys_rst_n=0: all counters and data = 0, cnt_sel = 0, sel = 000000, seg = FF, ds = 0, shcp = 0, stcp = 0, oe = 1.
REQ-025 Reset assertion mid-frame SHALL immediately force REQ-024 values; after release, first frame starts at cnt_bit=0.

Verification (bench overrides DATA_CNT_MAX=49, SCAN_CNT_MAX=19, 20 ns clock)
REQ-026 Reset held 100 ns -> stcp=shcp=ds=0, oe=1 throughout; oe=0 after release.
REQ-027 After release -> shcp toggles with 80 ns period; stcp one-clock pulses spaced 56 clocks (1120 ns).
REQ-028 data increments every 50 clocks: 0,1,2,... ; after 1000000 increments wraps to 0.
REQ-029 data=0, cnt_sel=0 -> deserialized frame sel=000001, seg=C0; cnt_sel=1 -> sel=000010, seg=FF (blanked).
REQ-030 data=123 -> digits units..hundreds decode to B0,A4,F9; higher three digits FF.
REQ-031 Assert reset mid-frame -> outputs return to REQ-024 values asynchronously; restart yields first stcp pulse at cnt_bit=0.

Source files
------------

// File: rtl/top_seg_595.sv
// Six-digit counter display: a 0..999999 counter is scanned digit by digit onto a
// common-anode 7-segment module and shifted out serially through two 74HC595s.

module data_gen #(
  parameter int CNT_MAX = 4999999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        seg_en,
  output logic        sign
);
  localparam int             CNT_W   = $clog2(CNT_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt  <= '0;
      data <= '0;
    end else begin
      cnt <= (cnt == CNT_TOP) ? '0 : cnt + 1'b1;
      if (cnt == CNT_TOP) data <= (data == 20'd999_999) ? '0 : data + 20'd1;
    end
  end

  assign point  = 6'b000000;
  assign seg_en = 1'b1;
  assign sign   = 1'b0;
endmodule

module seg_dynamic #(
  parameter int CNT_MAX = 49999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        seg_en,
  input  logic        sign,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);
  localparam int               CNT_W   = $clog2(CNT_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
  localparam logic [3:0]       G_MINUS = 4'd10;
  localparam logic [3:0]       G_BLANK = 4'd11;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       cnt_sel;
  logic [23:0]      bcd;
  logic [2:0]       msd;
  logic [3:0]       glyph [6];

  function automatic logic [7:0] seg_code(input logic [3:0] g);
    case (g)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      G_MINUS: seg_code = 8'hBF;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // NOTE: blocking assignments here on purpose: each shift-add-3 step reads the previous step's result.
  always_comb begin
    bcd = '0;
    for (int i = 19; i >= 0; i--) begin
      for (int d = 0; d < 6; d++)
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      bcd = {bcd[22:0], data[i]};
    end
  end

  // NOTE: every output gets a default before any condition, so no latch is inferred.
  always_comb begin
    msd = '0;
    for (int d = 0; d < 6; d++)
      if (bcd[4*d +: 4] != 4'd0) msd = 3'(d);
    for (int d = 0; d < 6; d++) begin
      glyph[d] = G_BLANK;
      if (3'(d) <= msd)                         glyph[d] = bcd[4*d +: 4];
      else if (sign && (3'(d) == msd + 3'd1))   glyph[d] = G_MINUS;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt     <= '0;
      cnt_sel <= '0;
      sel     <= '0;
      seg     <= 8'hFF;
    end else begin
      cnt <= (cnt == CNT_TOP) ? '0 : cnt + 1'b1;
      if (cnt == CNT_TOP) cnt_sel <= (cnt_sel == 3'd5) ? '0 : cnt_sel + 3'd1;
      // sel and seg come from the same cnt_sel so the lit digit and its pattern never skew.
      sel <= seg_en ? (6'b000001 << cnt_sel) : 6'b000000;
      seg <= {~point[cnt_sel], seg_code(glyph[cnt_sel])[6:0]};
    end
  end
endmodule

module hc595_ctrl (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [5:0] sel,
  input  logic [7:0] seg,
  output logic       stcp,
  output logic       shcp,
  output logic       ds,
  output logic       oe
);
  logic [1:0]  cnt_4;
  logic [3:0]  cnt_bit;
  logic [13:0] frame;

  // sel[0] leaves first, seg[0] last, matching the daisy-chained 595 wiring.
  assign frame = {seg[0], seg[1], seg[2], seg[3], seg[4], seg[5], seg[6], seg[7], sel};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_4   <= '0;
      cnt_bit <= '0;
      ds      <= 1'b0;
      shcp    <= 1'b0;
      stcp    <= 1'b0;
    end else begin
      cnt_4 <= cnt_4 + 2'd1;
      if (cnt_4 == 2'd3) cnt_bit <= (cnt_bit == 4'd13) ? '0 : cnt_bit + 4'd1;
      if (cnt_4 == 2'd0) ds <= frame[cnt_bit];
      if (cnt_4 == 2'd0)      shcp <= 1'b0;
      else if (cnt_4 == 2'd2) shcp <= 1'b1;
      stcp <= (cnt_bit == 4'd0) && (cnt_4 == 2'd0);
    end
  end

  assign oe = ~sys_rst_n;
endmodule

module seg_595_dynamic #(
  parameter int CNT_MAX = 49999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        seg_en,
  input  logic        sign,
  output logic        stcp,
  output logic        shcp,
  output logic        ds,
  output logic        oe
);
  logic [5:0] sel;
  logic [7:0] seg;

  seg_dynamic #(.CNT_MAX(CNT_MAX)) seg_dynamic_inst (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .point(point),
    .seg_en(seg_en), .sign(sign), .sel(sel), .seg(seg)
  );

  hc595_ctrl hc595_ctrl_inst (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sel(sel), .seg(seg),
    .stcp(stcp), .shcp(shcp), .ds(ds), .oe(oe)
  );
endmodule

module top_seg_595 #(
  parameter int DATA_CNT_MAX = 4999999,
  parameter int SCAN_CNT_MAX = 49999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic stcp,
  output logic shcp,
  output logic ds,
  output logic oe
);
  logic [19:0] data;
  logic [5:0]  point;
  logic        seg_en;
  logic        sign;

  data_gen #(.CNT_MAX(DATA_CNT_MAX)) data_gen_inst (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .point(point),
    .seg_en(seg_en), .sign(sign)
  );

  seg_595_dynamic #(.CNT_MAX(SCAN_CNT_MAX)) seg_595_dynamic_inst (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .data(data), .point(point),
    .seg_en(seg_en), .sign(sign), .stcp(stcp), .shcp(shcp), .ds(ds), .oe(oe)
  );
endmodule

// File: tb/tb_top_seg_595.sv
// Bench for top_seg_595: per-cycle serial-output model on two parameterisations,
// digit-decode vector table, and randomly timed mid-frame resets.

module tb_top_seg_595;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stcp_a, shcp_a, ds_a, oe_a;
  logic stcp_b, shcp_b, ds_b, oe_b;

  int checks = 0;
  int failures = 0;
  int e = 0;  // index of the next rising edge since reset release

  // Slow scan like the board (scaled), and a fast one where every clock shows a new digit.
  top_seg_595 #(.DATA_CNT_MAX(49), .SCAN_CNT_MAX(19)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .stcp(stcp_a), .shcp(shcp_a), .ds(ds_a), .oe(oe_a)
  );
  top_seg_595 #(.DATA_CNT_MAX(5), .SCAN_CNT_MAX(0)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .stcp(stcp_b), .shcp(shcp_b), .ds(ds_b), .oe(oe_b)
  );

  always #10 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] seg_lut [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    int         value;
    int         idx;
    logic [7:0] seg;
    logic [5:0] sel;
  } vec_t;
  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pattern for one digit position of a decimal value, leading zeros blanked, no sign, DPs off.
  function automatic logic [7:0] digit_seg(input int value, input int idx);
    int msd = 0;
    int p = 1;
    int dig = 0;
    for (int i = 0; i < 6; i++) begin
      if ((value / p) % 10 != 0) msd = i;
      if (i == idx) dig = (value / p) % 10;
      p = p * 10;
    end
    if (idx > msd) return 8'hFF;
    return seg_lut[dig];
  endfunction

  function automatic logic frame_bit(input int value, input int idx, input int b);
    logic [7:0] s;
    s = digit_seg(value, idx);
    if (b < 6) return (b == idx);
    return s[13-b];
  endfunction

  // {stcp, shcp, ds, oe} after rising edge k since release; dp/sp are the data/scan periods.
  // The frame bit loaded at edge k4 reflects the display contents registered at edge k4-1.
  function automatic logic [3:0] exp_out(input int k, input int dp, input int sp);
    int  k4;
    int  b;
    logic ds_e;
    k4 = k - (k % 4);
    b  = (k4 / 4) % 14;
    if (k4 == 0) ds_e = 1'b0;
    else ds_e = frame_bit(((k4 - 1) / dp) % 1000000, ((k4 - 1) / sp) % 6, b);
    return {(k % 56) == 0, (k % 4) >= 2, ds_e, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check($sformatf("a_out[%0d]", e), {28'd0, stcp_a, shcp_a, ds_a, oe_a}, {28'd0, exp_out(e, 50, 20)});
    check($sformatf("b_out[%0d]", e), {28'd0, stcp_b, shcp_b, ds_b, oe_b}, {28'd0, exp_out(e, 6, 1)});
    e++;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {24'd0, stcp_a, shcp_a, ds_a, oe_a, stcp_b, shcp_b, ds_b, oe_b}, 32'b0001_0001);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("oe_after_release", {30'd0, oe_a, oe_b}, 32'd0);
    e = 0;
  endtask

  initial begin
    int target;
    vecs.push_back('{0,    0, 8'hC0, 6'h01});
    vecs.push_back('{0,    1, 8'hFF, 6'h02});
    vecs.push_back('{0,    5, 8'hFF, 6'h20});
    vecs.push_back('{7,    0, 8'hF8, 6'h01});
    vecs.push_back('{10,   0, 8'hC0, 6'h01});
    vecs.push_back('{10,   1, 8'hF9, 6'h02});
    vecs.push_back('{10,   2, 8'hFF, 6'h04});
    vecs.push_back('{123,  0, 8'hB0, 6'h01});
    vecs.push_back('{123,  1, 8'hA4, 6'h02});
    vecs.push_back('{123,  2, 8'hF9, 6'h04});
    vecs.push_back('{123,  3, 8'hFF, 6'h08});
    vecs.push_back('{123,  4, 8'hFF, 6'h10});
    vecs.push_back('{123,  5, 8'hFF, 6'h20});
    vecs.push_back('{405,  0, 8'h92, 6'h01});
    vecs.push_back('{405,  1, 8'hC0, 6'h02});
    vecs.push_back('{405,  2, 8'h99, 6'h04});
    vecs.push_back('{5060, 1, 8'h82, 6'h02});
    vecs.push_back('{5060, 3, 8'h92, 6'h08});
    vecs.push_back('{5060, 4, 8'hFF, 6'h10});

    // 100 ns of reset: all serial outputs low, oe high.
    repeat (5) begin
      @(negedge clk);
      check_reset_outputs("in_reset");
    end
    release_reset();

    // dut_b shows data=floor(k/6) on digit k%6 right after edge k.
    foreach (vecs[t]) begin
      target = vecs[t].value * 6 + vecs[t].idx;
      while (e <= target) step();
      check($sformatf("vec%0d_seg(v=%0d,d=%0d)", t, vecs[t].value, vecs[t].idx),
            {24'd0, dut_b.seg_595_dynamic_inst.seg_dynamic_inst.seg}, {24'd0, vecs[t].seg});
      check($sformatf("vec%0d_sel(v=%0d,d=%0d)", t, vecs[t].value, vecs[t].idx),
            {26'd0, dut_b.seg_595_dynamic_inst.seg_dynamic_inst.sel}, {26'd0, vecs[t].sel});
    end

    // Reset asserted at random points mid-frame, held, then released and re-checked from edge 0.
    for (int ep = 0; ep < 4; ep++) begin
      repeat ($urandom_range(100, 400)) step();
      @(posedge clk);
      #($urandom_range(2, 8));
      rst_n = 1'b0;
      #1;
      check($sformatf("async_reset%0d", ep), {24'd0, stcp_a, shcp_a, ds_a, oe_a, stcp_b, shcp_b, ds_b, oe_b},
            32'b0001_0001);
      check($sformatf("async_reset%0d_display", ep),
            {18'd0, dut.seg_595_dynamic_inst.seg_dynamic_inst.sel, dut.seg_595_dynamic_inst.seg_dynamic_inst.seg},
            {18'd0, 6'h00, 8'hFF});
      repeat ($urandom_range(2, 5)) begin
        @(negedge clk);
        check_reset_outputs($sformatf("held_reset%0d", ep));
      end
      release_reset();
      repeat ($urandom_range(150, 600)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
